// File: rtl/write_out_gen_if.sv
// write_out_gen_if: bundles the beat handshake, tile control and SRAM write
// buses of the write-out sequencer.
//   slave  : sequencer side (takes start/beats, drives SRAM ports and status)
//   master : producer/bench side (drives start/beats, observes everything else)
// Signals:
//   start, bank_sel, base_addr          tile control (latched on start)
//   in_valid, in_ready, in_data         diagonal beat handshake
//   sram_wen_n, sram_waddr, sram_wdata  per-bank write ports (wen_n 0 = write)
//   busy, done, sel_err                 status
interface write_out_gen_if #(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_WIDTH = 24,
  parameter int NUM_BANKS  = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int BSEL_WIDTH = 2
) ();
  logic                                        start;
  logic [BSEL_WIDTH-1:0]                       bank_sel;
  logic [ADDR_WIDTH-1:0]                       base_addr;
  logic                                        in_valid;
  logic                                        in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0]            in_data;
  logic [NUM_BANKS-1:0]                        sram_wen_n;
  logic [NUM_BANKS*ADDR_WIDTH-1:0]             sram_waddr;
  logic [NUM_BANKS*ARRAY_SIZE*DATA_WIDTH-1:0]  sram_wdata;
  logic                                        busy;
  logic                                        done;
  logic                                        sel_err;

  modport slave (
    input  start, bank_sel, base_addr, in_valid, in_data,
    output in_ready, sram_wen_n, sram_waddr, sram_wdata, busy, done, sel_err
  );

  modport master (
    output start, bank_sel, base_addr, in_valid, in_data,
    input  in_ready, sram_wen_n, sram_waddr, sram_wdata, busy, done, sel_err
  );
endinterface

// File: rtl/write_out_gen.sv
// write_out_gen: de-skews one systolic-array output diagonal per accepted
// beat into row-aligned SRAM words. A tile is 2*ARRAY_SIZE-1 diagonals; the
// primary bank receives every diagonal, the next bank (mod NUM_BANKS) also
// receives the trailing half. done pulses together with the last write.
// Ports:
//   clk    rising-edge clock
//   srstn  asynchronous active-low reset
//   bus    write_out_gen_if.slave (control, beat handshake, SRAM ports, status)
module write_out_gen #(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_WIDTH = 24,
  parameter int NUM_BANKS  = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int BSEL_WIDTH = 2
) (
  input  logic            clk,
  input  logic            srstn,
  write_out_gen_if.slave  bus
);
  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int WW = N * DW;
  localparam int CW = $clog2(2 * N - 1);
  localparam logic [CW-1:0] LAST_D = CW'(2 * N - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            d_q;
  logic [BSEL_WIDTH-1:0]    p_q;
  logic [AW-1:0]            base_q;
  logic                     sel_err_q;
  logic                     done_q;
  logic [NUM_BANKS-1:0]     wen_q, wen_d;
  logic [NUM_BANKS*AW-1:0]  waddr_q, waddr_d;
  logic [NUM_BANKS*WW-1:0]  wdata_q, wdata_d;

  logic                     accept_s;
  logic                     upper_s;
  int                       d_int_s;
  logic [BSEL_WIDTH-1:0]    sec_bank_s;
  logic [AW-1:0]            prim_addr_s;
  logic [AW-1:0]            sec_addr_s;
  logic [WW-1:0]            prim_word_s;
  logic [WW-1:0]            sec_word_s;

  // Secondary bank is the primary index plus one, wrapping at NUM_BANKS.
  function automatic logic [BSEL_WIDTH-1:0] next_bank(input logic [BSEL_WIDTH-1:0] p);
    if (32'(p) >= 32'(NUM_BANKS - 1)) begin
      return '0;
    end else begin
      return p + BSEL_WIDTH'(1);
    end
  endfunction

  assign accept_s    = bus.in_valid && (state_q == RUN);
  assign upper_s     = (32'(d_q) >= 32'(N));
  assign d_int_s     = int'(d_q);
  assign sec_bank_s  = next_bank(p_q);
  // Sums are formed wide and truncated, so addresses wrap modulo 2^AW.
  assign prim_addr_s = AW'(32'(base_q) + 32'(d_q));
  assign sec_addr_s  = AW'(32'(base_q) + 32'(d_q) - 32'(N));

  // De-skew: lane i lands in slot N-1-i; in the trailing half the primary
  // word takes the lanes shifted by d-N+1 and the secondary word the head.
  always_comb begin
    prim_word_s = '0;
    sec_word_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (!upper_s) begin
        if (i <= d_int_s) begin
          prim_word_s[(N-1-i)*DW +: DW] = bus.in_data[i*DW +: DW];
        end else begin
          prim_word_s[(N-1-i)*DW +: DW] = '0;
        end
      end else begin
        if (i < 2 * N - 1 - d_int_s) begin
          prim_word_s[(N-1-i)*DW +: DW] = bus.in_data[(i+1+d_int_s-N)*DW +: DW];
        end else begin
          prim_word_s[(N-1-i)*DW +: DW] = '0;
        end
        if (i <= d_int_s - N) begin
          sec_word_s[(N-1-i)*DW +: DW] = bus.in_data[i*DW +: DW];
        end else begin
          sec_word_s[(N-1-i)*DW +: DW] = '0;
        end
      end
    end
  end

  // Route the words onto the bank ports; unwritten banks present idle values.
  always_comb begin
    wen_d   = {NUM_BANKS{1'b1}};
    waddr_d = '0;
    wdata_d = '0;
    if (accept_s && !sel_err_q) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (32'(p_q) == 32'(k)) begin
          wen_d[k]             = 1'b0;
          waddr_d[k*AW +: AW]  = prim_addr_s;
          wdata_d[k*WW +: WW]  = prim_word_s;
        end else if (upper_s && (32'(sec_bank_s) == 32'(k))) begin
          wen_d[k]             = 1'b0;
          waddr_d[k*AW +: AW]  = sec_addr_s;
          wdata_d[k*WW +: WW]  = sec_word_s;
        end else begin
          wen_d[k]             = 1'b1;
        end
      end
    end else begin
      wen_d = {NUM_BANKS{1'b1}};
    end
  end

  // Tile FSM, diagonal counter and registered SRAM/status outputs.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q   <= IDLE;
      d_q       <= '0;
      p_q       <= '0;
      base_q    <= '0;
      sel_err_q <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= {NUM_BANKS{1'b1}};
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // in_valid is ignored here even if high alongside start.
          if (bus.start) begin
            p_q       <= bus.bank_sel;
            base_q    <= bus.base_addr;
            d_q       <= '0;
            sel_err_q <= (32'(bus.bank_sel) >= 32'(NUM_BANKS));
            state_q   <= RUN;
          end else begin
            state_q   <= IDLE;
          end
        end
        RUN: begin
          if (accept_s) begin
            if (d_q == LAST_D) begin
              d_q     <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              d_q     <= d_q + CW'(1);
            end
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_q == RUN);
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.sram_wen_n = wen_q;
  assign bus.sram_waddr = waddr_q;
  assign bus.sram_wdata = wdata_q;
endmodule

// File: tb/tb_write_out_gen.sv
module tb_write_out_gen;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int NB   = 3;
  localparam int AW   = 6;
  localparam int BW   = 2;
  localparam int WW   = N * DW;
  localparam int LAST = 2 * N - 2;

  logic clk = 1'b0;
  logic srstn;
  always #5 clk = ~clk;

  write_out_gen_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .NUM_BANKS(NB),
                     .ADDR_WIDTH(AW), .BSEL_WIDTH(BW)) bus ();

  write_out_gen #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .NUM_BANKS(NB),
                  .ADDR_WIDTH(AW), .BSEL_WIDTH(BW)) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference expectations for one cycle
  logic [NB-1:0] m_wen;
  logic [AW-1:0] m_addr [NB];
  logic [WW-1:0] m_data [NB];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int l = 0; l < N; l++) w[l*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Expected bank writes for one cycle, built slot by slot from the de-skew rules.
  task automatic model_beat(input int p, input int b, input int d,
                            input logic [WW-1:0] data, input bit err, input bit v);
    logic [DW-1:0] lane [N];
    logic [DW-1:0] pw [N];
    logic [DW-1:0] sw [N];
    int s;
    int i;
    for (int k = 0; k < NB; k++) begin
      m_wen[k] = 1'b1; m_addr[k] = '0; m_data[k] = '0;
    end
    for (int l = 0; l < N; l++) begin
      lane[l] = data[l*DW +: DW]; pw[l] = '0; sw[l] = '0;
    end
    if (v && !err) begin
      s = (p + 1) % NB;
      for (int j = 0; j < N; j++) begin
        i = N - 1 - j;
        if (d < N) begin
          if (i <= d) pw[j] = lane[i];
        end else begin
          if (i < 2 * N - 1 - d) pw[j] = lane[i + 1 + d - N];
          if (i <= d - N) sw[j] = lane[i];
        end
      end
      m_wen[p] = 1'b0;
      m_addr[p] = AW'((b + d) % (1 << AW));
      for (int j = 0; j < N; j++) m_data[p][j*DW +: DW] = pw[j];
      if (d >= N) begin
        m_wen[s] = 1'b0;
        m_addr[s] = AW'((b + d - N) % (1 << AW));
        for (int j = 0; j < N; j++) m_data[s][j*DW +: DW] = sw[j];
      end
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    bus.start = 1'b0; bus.bank_sel = '0; bus.base_addr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) tick();
    checks++;
    if (bus.sram_wen_n !== {NB{1'b1}} || bus.sram_waddr !== '0 || bus.sram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_sram: wen=%b addr=%h data=%h, want all-ones/0/0",
               bus.sram_wen_n, bus.sram_waddr, bus.sram_wdata);
    end
    checks++;
    if ({bus.busy, bus.in_ready, bus.done, bus.sel_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: busy/ready/done/sel_err=%b, want 0000",
               {bus.busy, bus.in_ready, bus.done, bus.sel_err});
    end
    srstn = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    bus.bank_sel = 2'd0; bus.base_addr = 6'd8; bus.start = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = rand_word();
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: busy=%b ready=%b sel_err=%b, want 1 1 0",
               bus.busy, bus.in_ready, bus.sel_err);
    end
    checks++;
    if (bus.sram_wen_n !== {NB{1'b1}}) begin
      errors++;
      $display("FAIL start_with_valid: wen=%b, want 111", bus.sram_wen_n);
    end
    bus.start = 1'b0;
    bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    checks++;
    if (bus.sram_wen_n !== 3'b110 || bus.sram_waddr[0 +: AW] !== 6'd8 ||
        bus.sram_wdata[0 +: WW] !== 32'h1100_0000) begin
      errors++;
      $display("FAIL d0_bank0: wen=%b addr=%0d data=%h, want 110 8 11000000",
               bus.sram_wen_n, bus.sram_waddr[0 +: AW], bus.sram_wdata[0 +: WW]);
    end
    checks++;
    if (bus.sram_waddr[AW +: 2*AW] !== '0 || bus.sram_wdata[WW +: 2*WW] !== '0) begin
      errors++;
      $display("FAIL d0_idle_banks: addr=%h data=%h, want 0",
               bus.sram_waddr[AW +: 2*AW], bus.sram_wdata[WW +: 2*WW]);
    end
    for (int d = 1; d <= 4; d++) begin
      bus.in_data = rand_word();
      tick();
    end
    bus.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    checks++;
    if (bus.sram_wen_n !== 3'b100 || bus.sram_waddr[0 +: AW] !== 6'd13 ||
        bus.sram_wdata[0 +: WW] !== 32'hA2A3_0000) begin
      errors++;
      $display("FAIL d5_primary: wen=%b addr=%0d data=%h, want 100 13 a2a30000",
               bus.sram_wen_n, bus.sram_waddr[0 +: AW], bus.sram_wdata[0 +: WW]);
    end
    checks++;
    if (bus.sram_waddr[AW +: AW] !== 6'd9 || bus.sram_wdata[WW +: WW] !== 32'hA0A1_0000 ||
        bus.sram_wdata[2*WW +: WW] !== '0) begin
      errors++;
      $display("FAIL d5_secondary: addr=%0d data=%h bank2=%h, want 9 a0a10000 0",
               bus.sram_waddr[AW +: AW], bus.sram_wdata[WW +: WW], bus.sram_wdata[2*WW +: WW]);
    end
    bus.in_data = rand_word();
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL last_beat: done=%b busy=%b ready=%b, want 1 0 0",
               bus.done, bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.sram_wen_n !== {NB{1'b1}}) begin
      errors++;
      $display("FAIL after_done: done=%b wen=%b, want 0 111", bus.done, bus.sram_wen_n);
    end
  endtask

  task automatic test_random_tile();
    int p, b, s, d, cyc, wp, ws, dones;
    bit v, exp_done;
    logic [WW-1:0] data;
    p = $urandom_range(0, NB - 1); b = $urandom_range(0, (1 << AW) - 1);
    s = (p + 1) % NB;
    bus.bank_sel = BW'(p); bus.base_addr = AW'(b); bus.start = 1'b1; bus.in_valid = 1'b0;
    tick();
    d = 0; cyc = 0; wp = 0; ws = 0; dones = 0;
    while (d <= LAST && cyc < 200) begin
      v = ($urandom_range(0, 2) != 0);
      data = rand_word();
      bus.in_valid = v; bus.in_data = data;
      tick();
      cyc++;
      model_beat(p, b, d, data, 1'b0, v);
      exp_done = v && (d == LAST);
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (bus.sram_wen_n[k] !== m_wen[k] || bus.sram_waddr[k*AW +: AW] !== m_addr[k] ||
            bus.sram_wdata[k*WW +: WW] !== m_data[k]) begin
          errors++;
          $display("FAIL rand_bank%0d d=%0d: got wen=%b addr=%0d data=%h, want wen=%b addr=%0d data=%h",
                   k, d, bus.sram_wen_n[k], bus.sram_waddr[k*AW +: AW], bus.sram_wdata[k*WW +: WW],
                   m_wen[k], m_addr[k], m_data[k]);
        end
      end
      checks++;
      if (bus.done !== exp_done || bus.busy !== !exp_done) begin
        errors++;
        $display("FAIL rand_status d=%0d: done=%b busy=%b, want %b %b",
                 d, bus.done, bus.busy, exp_done, !exp_done);
      end
      if (bus.sram_wen_n[p] === 1'b0) wp++;
      if (bus.sram_wen_n[s] === 1'b0) ws++;
      if (bus.done === 1'b1) dones++;
      if (v) d++;
    end
    checks++;
    if (wp != 2 * N - 1 || ws != N - 1 || dones != 1) begin
      errors++;
      $display("FAIL rand_counts: primary=%0d secondary=%0d dones=%0d, want %0d %0d 1",
               wp, ws, dones, 2 * N - 1, N - 1);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL held_start: busy=%b after done cycle, want 1", bus.busy);
    end
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int n = 0; n <= LAST; n++) begin
      bus.in_data = rand_word();
      tick();
      checks++;
      if (bus.done !== (n == LAST)) begin
        errors++;
        $display("FAIL second_tile_done beat=%0d: done=%b, want %b", n, bus.done, n == LAST);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [WW-1:0] data;
    bus.bank_sel = 2'd2; bus.base_addr = 6'd62; bus.start = 1'b1; bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int d = 0; d <= LAST; d++) begin
      data = rand_word();
      bus.in_data = data;
      tick();
      model_beat(2, 62, d, data, 1'b0, 1'b1);
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (bus.sram_wen_n[k] !== m_wen[k] || bus.sram_waddr[k*AW +: AW] !== m_addr[k] ||
            bus.sram_wdata[k*WW +: WW] !== m_data[k]) begin
          errors++;
          $display("FAIL wrap_bank%0d d=%0d: got wen=%b addr=%0d data=%h, want wen=%b addr=%0d data=%h",
                   k, d, bus.sram_wen_n[k], bus.sram_waddr[k*AW +: AW], bus.sram_wdata[k*WW +: WW],
                   m_wen[k], m_addr[k], m_data[k]);
        end
      end
      if (d == LAST) begin
        checks++;
        if (bus.sram_wen_n !== 3'b010 || bus.sram_waddr[2*AW +: AW] !== 6'd4 ||
            bus.sram_waddr[0 +: AW] !== 6'd0) begin
          errors++;
          $display("FAIL wrap_addr: wen=%b bank2=%0d bank0=%0d, want 010 4 0",
                   bus.sram_wen_n, bus.sram_waddr[2*AW +: AW], bus.sram_waddr[0 +: AW]);
        end
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sel_err();
    int acc, cyc;
    bit v, any_write, exp_done;
    bus.bank_sel = 2'd3; bus.base_addr = AW'($urandom); bus.start = 1'b1; bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.sel_err !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL sel_err_set: sel_err=%b busy=%b, want 1 1", bus.sel_err, bus.busy);
    end
    acc = 0; cyc = 0; any_write = 1'b0;
    while (acc <= LAST && cyc < 200) begin
      v = ($urandom_range(0, 3) != 0);
      bus.in_valid = v; bus.in_data = rand_word();
      tick();
      cyc++;
      exp_done = v && (acc == LAST);
      if (bus.sram_wen_n !== {NB{1'b1}}) any_write = 1'b1;
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL sel_err_done beat=%0d: done=%b, want %b", acc, bus.done, exp_done);
      end
      if (v) acc++;
    end
    checks++;
    if (any_write || acc != LAST + 1 || bus.sel_err !== 1'b1) begin
      errors++;
      $display("FAIL sel_err_tile: wrote=%b beats=%0d sel_err=%b, want 0 %0d 1",
               any_write, acc, bus.sel_err, LAST + 1);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int p, b, cyc, d;
    bit v, exp_done;
    logic [WW-1:0] data;
    bus.bank_sel = 2'd1; bus.base_addr = AW'($urandom); bus.start = 1'b1; bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_clear: sel_err=%b, want 0", bus.sel_err);
    end
    bus.in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      bus.in_data = rand_word();
      tick();
    end
    #2 srstn = 1'b0;
    #1;
    checks++;
    if (bus.sram_wen_n !== {NB{1'b1}} || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wen=%b busy=%b ready=%b done=%b, want 111 0 0 0",
               bus.sram_wen_n, bus.busy, bus.in_ready, bus.done);
    end
    bus.in_valid = 1'b0;
    tick();
    srstn = 1'b1;
    tick();
    p = $urandom_range(0, NB - 1); b = $urandom_range(0, (1 << AW) - 1);
    bus.bank_sel = BW'(p); bus.base_addr = AW'(b); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    d = 0; cyc = 0;
    while (d <= LAST && cyc < 200) begin
      v = ($urandom_range(0, 3) != 0);
      data = rand_word();
      bus.in_valid = v; bus.in_data = data;
      tick();
      cyc++;
      model_beat(p, b, d, data, 1'b0, v);
      exp_done = v && (d == LAST);
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (bus.sram_wen_n[k] !== m_wen[k] || bus.sram_waddr[k*AW +: AW] !== m_addr[k] ||
            bus.sram_wdata[k*WW +: WW] !== m_data[k]) begin
          errors++;
          $display("FAIL post_reset_bank%0d d=%0d: got wen=%b addr=%0d data=%h, want wen=%b addr=%0d data=%h",
                   k, d, bus.sram_wen_n[k], bus.sram_waddr[k*AW +: AW], bus.sram_wdata[k*WW +: WW],
                   m_wen[k], m_addr[k], m_data[k]);
        end
      end
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL post_reset_done d=%0d: done=%b, want %b", d, bus.done, exp_done);
      end
      if (v) d++;
    end
    checks++;
    if (d != LAST + 1) begin
      errors++;
      $display("FAIL post_reset_timeout: beats=%0d, want %0d", d, LAST + 1);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    for (int r = 0; r < 4; r++) test_random_tile();
    test_wrap();
    test_sel_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
